// File: rtl/tft_spi_reader.sv
// tft_spi_reader
//
// Read-back engine for the TFT panel's 4-wire SPI port (mode 0). A transaction
// sends one command byte with D/C low, then clocks a programmable number of
// dummy bits, then shifts 1-4 response bytes in from the panel's MISO line.
// The game top muxes the shared tft_* pins onto this block while busy is high.
//
// Ports:
//   clk         system clock (single clock domain)
//   rst         synchronous active-high reset
//   start       request a transaction; only sampled while idle
//   cmd         command byte, sent MSB first
//   dummy_bits  number of dummy SCK cycles (0-15)
//   rd_bytes    number of response bytes minus one (1-4 bytes)
//   busy        high from the cycle after start is accepted through done
//   done        one-cycle pulse at the end of a transaction
//   rd_data     response, right-aligned, first received bit most significant
//   tft_sck     SPI clock, idles low
//   tft_sdi     MOSI
//   tft_dc      0 during the command byte, 1 otherwise
//   tft_cs      chip select, active low
//   tft_sdo     MISO from the panel
//
// Timing: each bit cell is 2*CLK_DIV clk cycles, low half first. A SETUP
// period of CLK_DIV cycles precedes the first bit and a HOLD period of CLK_DIV
// cycles follows the last, so a transaction takes 2*CLK_DIV*(9 + D + 8N)
// cycles from the accepting edge to the edge that raises done.

module tft_spi_reader #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [3:0]  dummy_bits,
    input  logic [1:0]  rd_bytes,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        tft_sck,
    output logic        tft_sdi,
    output logic        tft_dc,
    output logic        tft_cs,
    input  logic        tft_sdo
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CMD,
        S_DUMMY,
        S_READ,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state;
    logic [HW-1:0]   hcnt;
    logic [5:0]      bit_cnt;
    logic [6:0]      cmd_sh;
    logic [3:0]      dummy_q;
    logic [1:0]      rd_q;
    logic            half_end;
    logic            last_bit;

    assign half_end = (hcnt == H_LAST);

    // bit_cnt counts bits within the current phase; this flags the final bit
    // of CMD, DUMMY or READ so the falling edge can move to the next phase.
    always_comb begin
        last_bit = 1'b0;
        case (state)
            S_CMD:   last_bit = (bit_cnt == 6'd7);
            S_DUMMY: last_bit = (bit_cnt == ({2'b00, dummy_q} - 6'd1));
            S_READ:  last_bit = (bit_cnt == {1'b0, rd_q, 3'b111});
            default: last_bit = 1'b0;
        endcase
    end

    // Single-process FSM. All pin outputs are registered here. sdi/dc only
    // change on the edge that drops sck (start of a low half), and MISO is
    // captured on the edge that raises sck, giving the panel a full half
    // period after its falling-edge launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            hcnt    <= '0;
            bit_cnt <= '0;
            cmd_sh  <= '0;
            dummy_q <= '0;
            rd_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
            tft_sck <= 1'b0;
            tft_sdi <= 1'b0;
            tft_dc  <= 1'b1;
            tft_cs  <= 1'b1;
        end else begin
            if (state != S_IDLE && state != S_DONE) begin
                hcnt <= half_end ? '0 : hcnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= S_SETUP;
                        hcnt    <= '0;
                        bit_cnt <= '0;
                        cmd_sh  <= cmd[6:0];
                        dummy_q <= dummy_bits;
                        rd_q    <= rd_bytes;
                        busy    <= 1'b1;
                        rd_data <= '0;
                        tft_cs  <= 1'b0;
                        tft_dc  <= 1'b0;
                        tft_sck <= 1'b0;
                        tft_sdi <= cmd[7];
                    end
                end

                S_SETUP: begin
                    if (half_end) begin
                        state <= S_CMD;
                    end
                end

                S_CMD, S_DUMMY, S_READ: begin
                    if (half_end) begin
                        if (!tft_sck) begin
                            tft_sck <= 1'b1;
                            if (state == S_READ) begin
                                rd_data <= {rd_data[30:0], tft_sdo};
                            end
                        end else begin
                            tft_sck <= 1'b0;
                            if (last_bit) begin
                                bit_cnt <= '0;
                                tft_dc  <= 1'b1;
                                tft_sdi <= 1'b0;
                                if (state == S_CMD) begin
                                    state <= (dummy_q == 4'd0) ? S_READ : S_DUMMY;
                                end else if (state == S_DUMMY) begin
                                    state <= S_READ;
                                end else begin
                                    state <= S_HOLD;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                                if (state == S_CMD) begin
                                    tft_sdi <= cmd_sh[6];
                                    cmd_sh  <= {cmd_sh[5:0], 1'b0};
                                end
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (half_end) begin
                        state  <= S_DONE;
                        tft_cs <= 1'b1;
                        done   <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tft_spi_reader.sv
// Testbench for tft_spi_reader.
//
// Two instances share the control inputs: u_dut0 with CLK_DIV=2 and u_dut1
// with CLK_DIV=1 (for the maximum-length read). A panel model, attached to
// whichever instance is selected, records MOSI and launches response bits on
// falling SCK edges. Directed vectors live in a struct table; reset-mid-read
// and start-held-high are written out by hand.

module tb_tft_spi_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cmd;
    logic [3:0]  dummy_bits;
    logic [1:0]  rd_bytes;
    logic        sel;
    logic        sdo;

    logic        busy0, done0, sck0, sdi0, dc0, cs0;
    logic        busy1, done1, sck1, sdi1, dc1, cs1;
    logic [31:0] rd0, rd1;

    logic        busy_m, done_m, sck_m, sdi_m, dc_m, cs_m;
    logic [31:0] rd_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tft_spi_reader #(.CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start & ~sel), .cmd(cmd),
        .dummy_bits(dummy_bits), .rd_bytes(rd_bytes),
        .busy(busy0), .done(done0), .rd_data(rd0),
        .tft_sck(sck0), .tft_sdi(sdi0), .tft_dc(dc0), .tft_cs(cs0),
        .tft_sdo(sdo)
    );

    tft_spi_reader #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start & sel), .cmd(cmd),
        .dummy_bits(dummy_bits), .rd_bytes(rd_bytes),
        .busy(busy1), .done(done1), .rd_data(rd1),
        .tft_sck(sck1), .tft_sdi(sdi1), .tft_dc(dc1), .tft_cs(cs1),
        .tft_sdo(sdo)
    );

    assign busy_m = sel ? busy1 : busy0;
    assign done_m = sel ? done1 : done0;
    assign sck_m  = sel ? sck1  : sck0;
    assign sdi_m  = sel ? sdi1  : sdi0;
    assign dc_m   = sel ? dc1   : dc0;
    assign cs_m   = sel ? cs1   : cs0;
    assign rd_m   = sel ? rd1   : rd0;

    // Panel model state
    int          rise_cnt = 0;
    int          cmd_dc_bad = 0;
    int          data_dc_bad = 0;
    logic [7:0]  mosi = 8'h00;
    logic [31:0] sl_resp = 32'h0;
    int          sl_dummy = 0;
    int          sl_bits = 8;

    // Counts rising SCK edges per transaction (reset when CS falls) and
    // records the command byte seen on MOSI along with the D/C level.
    always @(posedge sck_m or negedge cs_m) begin
        if (sck_m) begin
            if (rise_cnt < 8) begin
                mosi = {mosi[6:0], sdi_m};
                if (dc_m) cmd_dc_bad++;
            end else if (!dc_m) begin
                data_dc_bad++;
            end
            rise_cnt++;
        end else begin
            rise_cnt    = 0;
            mosi        = 8'h00;
            cmd_dc_bad  = 0;
            data_dc_bad = 0;
        end
    end

    // The panel launches the next response bit on each falling SCK edge.
    always @(negedge sck_m) begin
        int idx;
        idx = rise_cnt - 8 - sl_dummy;
        if (idx >= 0 && idx < sl_bits) sdo = sl_resp[sl_bits - 1 - idx];
        else sdo = 1'b0;
    end

    typedef struct {
        string       name;
        logic        sel;
        int          mode;
        logic [7:0]  cmd;
        logic [3:0]  dummy;
        logic [1:0]  rb;
        logic [31:0] resp;
        logic [31:0] exp_data;
        int          exp_t;
        int          exp_rises;
    } vec_t;

    // Results of the last applyStimulus call
    logic        accept_busy, accept_cs, done_after, busy_after;
    logic [31:0] got_data, hold_data;
    int          got_t, got_rises, dc_rise_fall, sck_cs_bad, falls;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // mode 0: single start pulse; mode 1: start toggles every cycle with
    // random command fields while the transaction runs.
    task automatic applyStimulus(input vec_t v);
        int   cyc;
        logic prev_sck, prev_dc, fell;
        sel      = v.sel;
        sl_resp  = v.resp;
        sl_dummy = int'(v.dummy);
        sl_bits  = 8 * (int'(v.rb) + 1);
        repeat (3) @(posedge clk);
        #1;
        cmd        = v.cmd;
        dummy_bits = v.dummy;
        rd_bytes   = v.rb;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        accept_busy = busy_m;
        accept_cs   = cs_m;
        cyc = 0; falls = 0; dc_rise_fall = -1; sck_cs_bad = 0;
        prev_sck = sck_m; prev_dc = dc_m;
        while (!done_m && cyc < 3000) begin
            if (v.mode == 1) begin
                start      = ~start;
                cmd        = 8'($urandom);
                dummy_bits = 4'($urandom);
                rd_bytes   = 2'($urandom);
            end
            @(posedge clk);
            #1;
            cyc++;
            fell = prev_sck && !sck_m;
            if (fell) falls++;
            if (!prev_dc && dc_m) dc_rise_fall = fell ? falls : -1;
            if (cs_m && sck_m) sck_cs_bad++;
            prev_sck = sck_m;
            prev_dc  = dc_m;
        end
        start     = 1'b0;
        got_t     = done_m ? cyc : -1;
        got_data  = rd_m;
        got_rises = rise_cnt;
        @(posedge clk);
        #1;
        done_after = done_m;
        busy_after = busy_m;
        hold_data  = rd_m;
    endtask

    initial begin
        vec_t vecs[5];
        int   cyc, dones, gap;
        logic seen_first, gap_open;
        logic [31:0] d1, d2;

        vecs[0] = '{"rddid", 1'b0, 0, 8'h04, 4'd1, 2'd2, 32'h009341, 32'h00009341, 136, 33};
        vecs[1] = '{"rddpm", 1'b0, 0, 8'h0A, 4'd0, 2'd0, 32'hA5, 32'h000000A5, 68, 16};
        vecs[2] = '{"mid",   1'b0, 0, 8'hDA, 4'd3, 2'd1, 32'h3C5A, 32'h00003C5A, 112, 27};
        vecs[3] = '{"pulse", 1'b0, 1, 8'h0A, 4'd0, 2'd0, 32'hA5, 32'h000000A5, 68, 16};
        vecs[4] = '{"max",   1'b1, 0, 8'hD3, 4'd15, 2'd3, 32'hDEADBEEF, 32'hDEADBEEF, 112, 55};

        sel = 1'b0; rst = 1'b1; start = 1'b0;
        cmd = 8'h00; dummy_bits = 4'd0; rd_bytes = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'b0, busy0}, 32'd0);
        checkOutput("rst_done", {31'b0, done0}, 32'd0);
        checkOutput("rst_rd",   rd0, 32'd0);
        checkOutput("rst_sck",  {31'b0, sck0}, 32'd0);
        checkOutput("rst_sdi",  {31'b0, sdi0}, 32'd0);
        checkOutput("rst_dc",   {31'b0, dc0}, 32'd1);
        checkOutput("rst_cs",   {31'b0, cs0}, 32'd1);
        checkOutput("rst_cs1",  {31'b0, cs1}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            checkOutput({vecs[i].name, "_accept_busy"}, {31'b0, accept_busy}, 32'd1);
            checkOutput({vecs[i].name, "_accept_cs"}, {31'b0, accept_cs}, 32'd0);
            checkOutput({vecs[i].name, "_T"}, 32'(got_t), 32'(vecs[i].exp_t));
            checkOutput({vecs[i].name, "_data"}, got_data, vecs[i].exp_data);
            checkOutput({vecs[i].name, "_rises"}, 32'(got_rises), 32'(vecs[i].exp_rises));
            checkOutput({vecs[i].name, "_mosi"}, {24'b0, mosi}, {24'b0, vecs[i].cmd});
            checkOutput({vecs[i].name, "_cmd_dc"}, 32'(cmd_dc_bad), 32'd0);
            checkOutput({vecs[i].name, "_data_dc"}, 32'(data_dc_bad), 32'd0);
            checkOutput({vecs[i].name, "_dc_rise"}, 32'(dc_rise_fall), 32'd8);
            checkOutput({vecs[i].name, "_sck_cs"}, 32'(sck_cs_bad), 32'd0);
            checkOutput({vecs[i].name, "_done_1cyc"}, {31'b0, done_after}, 32'd0);
            checkOutput({vecs[i].name, "_busy_end"}, {31'b0, busy_after}, 32'd0);
            checkOutput({vecs[i].name, "_hold"}, hold_data, vecs[i].exp_data);
        end

        // Reset in the high half of the 12th READ bit of an RDDID read
        // (8 cmd + 1 dummy + 11 read bits done, 21st rising edge seen).
        sel = 1'b0; sl_resp = 32'h009341; sl_dummy = 1; sl_bits = 24;
        @(posedge clk);
        #1;
        cmd = 8'h04; dummy_bits = 4'd1; rd_bytes = 2'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (rise_cnt < 21 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("rst_mid_reached", {31'b0, (rise_cnt == 21)}, 32'd1);
        checkOutput("rst_mid_sck_high", {31'b0, sck0}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_cs",   {31'b0, cs0}, 32'd1);
        checkOutput("rst_mid_sck",  {31'b0, sck0}, 32'd0);
        checkOutput("rst_mid_busy", {31'b0, busy0}, 32'd0);
        checkOutput("rst_mid_done", {31'b0, done0}, 32'd0);
        checkOutput("rst_mid_rd",   rd0, 32'd0);
        checkOutput("rst_mid_dc",   {31'b0, dc0}, 32'd1);
        rst = 1'b0;
        applyStimulus(vecs[0]);
        checkOutput("after_rst_T", 32'(got_t), 32'd136);
        checkOutput("after_rst_data", got_data, 32'h00009341);

        // start held high: two back-to-back RDDPM reads.
        sel = 1'b0; sl_resp = 32'hA5; sl_dummy = 0; sl_bits = 8;
        @(posedge clk);
        #1;
        cmd = 8'h0A; dummy_bits = 4'd0; rd_bytes = 2'd0; start = 1'b1;
        cyc = 0; dones = 0; gap = 0; seen_first = 1'b0; gap_open = 1'b0;
        d1 = 32'h0; d2 = 32'h0;
        while (dones < 2 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (gap_open) begin
                if (cs0) gap++;
                else gap_open = 1'b0;
            end
            if (done0) begin
                dones++;
                if (!seen_first) begin
                    d1 = rd0; seen_first = 1'b1; gap_open = 1'b1; gap = 1;
                end else begin
                    d2 = rd0;
                end
            end
        end
        start = 1'b0;
        checkOutput("held_dones", 32'(dones), 32'd2);
        checkOutput("held_gap_ge2", {31'b0, (gap >= 2)}, 32'd1);
        checkOutput("held_data1", d1, 32'h000000A5);
        checkOutput("held_data2", d2, 32'h000000A5);
        repeat (80) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
